// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO definitions: default address width and Gray/binary
// conversion helpers usable by both the read and write pointer blocks.
package fifo_pkg;

   localparam int N_ADDR = 4;

   // Operands are zero-extended to 32 bits, so any pointer width up to 32 converts correctly.
   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] gray);
      logic [31:0] bin;
      bin[31] = gray[31];
      for (int i = 30; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Combinational Gray-to-binary converter of width W.
module gray2bin_n
   import fifo_pkg::*;
#(
   parameter int W = N_ADDR + 1
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);

   assign bin = W'(gray2bin(32'(gray)));

endmodule

// File: rtl/rptr_empty.sv
// Read-side pointer, empty/almost-empty flags, fill level and sticky underflow
// for the dual-clock FIFO; all state lives in the rclk domain.
module rptr_empty
   import fifo_pkg::*;
#(
   parameter int n        = N_ADDR,
   parameter int AE_LEVEL = 2
) (
   input  logic         rclk,
   input  logic         rrst,
   input  logic         rinc,
   input  logic         rclr_err,
   input  logic [n:0]   rq2_wptr,
   output logic [n-1:0] raddr,
   output logic [n:0]   rptr,
   output logic         rempty,
   output logic         raempty,
   output logic [n:0]   rlevel,
   output logic         runderflow
);

   localparam int             PTR_W    = n + 1;
   localparam logic [PTR_W-1:0] AE_LVL_C = PTR_W'(AE_LEVEL);

   logic [PTR_W-1:0] rbin_r;
   logic [PTR_W-1:0] rbnext_s;
   logic [PTR_W-1:0] rgnext_s;
   logic [PTR_W-1:0] wbin_s;
   logic [PTR_W-1:0] lvl_next_s;
   logic             pop_s;

   gray2bin_n #(.W(PTR_W)) u_wbin (
      .gray (rq2_wptr),
      .bin  (wbin_s)
   );

   // Next-pointer and next-level computation; flags compare against the post-pop pointer.
   always_comb begin
      pop_s      = rinc & ~rempty;
      rbnext_s   = rbin_r + {{n{1'b0}}, pop_s};
      rgnext_s   = PTR_W'(bin2gray(32'(rbnext_s)));
      lvl_next_s = wbin_s - rbnext_s;
   end

   assign raddr = rbin_r[n-1:0];

   // Pointer, flag and level registers; set of underflow takes priority over clear.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         rbin_r     <= {PTR_W{1'b0}};
         rptr       <= {PTR_W{1'b0}};
         rempty     <= 1'b1;
         raempty    <= 1'b1;
         rlevel     <= {PTR_W{1'b0}};
         runderflow <= 1'b0;
      end else begin
         rbin_r  <= rbnext_s;
         rptr    <= rgnext_s;
         rempty  <= (rgnext_s == rq2_wptr);
         raempty <= (lvl_next_s <= AE_LVL_C);
         rlevel  <= lvl_next_s;
         if (rinc && rempty) begin
            runderflow <= 1'b1;
         end else if (rclr_err) begin
            runderflow <= 1'b0;
         end else begin
            runderflow <= runderflow;
         end
      end
   end

endmodule

// File: tb/tb_rptr_empty.sv
// Directed self-checking bench for rptr_empty (n=4, AE_LEVEL=2).
module tb_rptr_empty;

   logic       rclk = 1'b0;
   logic       rrst;
   logic       rinc;
   logic       rclr_err;
   logic [4:0] rq2_wptr;
   logic [3:0] raddr;
   logic [4:0] rptr;
   logic       rempty;
   logic       raempty;
   logic [4:0] rlevel;
   logic       runderflow;

   int checks = 0;
   int errors = 0;

   rptr_empty #(.n(4), .AE_LEVEL(2)) dut (
      .rclk       (rclk),
      .rrst       (rrst),
      .rinc       (rinc),
      .rclr_err   (rclr_err),
      .rq2_wptr   (rq2_wptr),
      .raddr      (raddr),
      .rptr       (rptr),
      .rempty     (rempty),
      .raempty    (raempty),
      .rlevel     (rlevel),
      .runderflow (runderflow)
   );

   always #5 rclk = ~rclk;

   task automatic step();
      @(posedge rclk);
      #1;
   endtask

   task automatic do_reset();
      rrst = 1'b1; rinc = 1'b0; rclr_err = 1'b0; rq2_wptr = 5'b00000;
      step();
      rrst = 1'b0;
   endtask

   task automatic test_reset();
      rrst = 1'b1; rinc = 1'b0; rclr_err = 1'b0; rq2_wptr = 5'b00000;
      step();
      step();
      rrst = 1'b0;
      checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty got %b exp 1", rempty); end
      checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL reset_raempty got %b exp 1", raempty); end
      checks++; if (rptr !== 5'd0) begin errors++; $display("FAIL reset_rptr got %b exp 00000", rptr); end
      checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL reset_raddr got %0d exp 0", raddr); end
      checks++; if (rlevel !== 5'd0) begin errors++; $display("FAIL reset_rlevel got %0d exp 0", rlevel); end
      checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL reset_runderflow got %b exp 0", runderflow); end
   endtask

   task automatic test_fill_drain();
      logic [4:0] exp_lvl [3];
      exp_lvl[0] = 5'd2; exp_lvl[1] = 5'd1; exp_lvl[2] = 5'd0;
      rq2_wptr = 5'b00010;
      step();
      checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL fill_rempty got %b exp 0", rempty); end
      checks++; if (rlevel !== 5'd3) begin errors++; $display("FAIL fill_rlevel got %0d exp 3", rlevel); end
      checks++; if (raempty !== 1'b0) begin errors++; $display("FAIL fill_raempty got %b exp 0", raempty); end
      rinc = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checks++; if (raddr !== 4'(k)) begin errors++; $display("FAIL drain_raddr%0d got %0d exp %0d", k, raddr, k); end
         step();
         checks++; if (rlevel !== exp_lvl[k]) begin errors++; $display("FAIL drain_rlevel%0d got %0d exp %0d", k, rlevel, exp_lvl[k]); end
         checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL drain_raempty%0d got %b exp 1", k, raempty); end
      end
      rinc = 1'b0;
      checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL drain_rempty got %b exp 1", rempty); end
      checks++; if (rptr !== 5'b00010) begin errors++; $display("FAIL drain_rptr got %b exp 00010", rptr); end
      checks++; if (raddr !== 4'd3) begin errors++; $display("FAIL drain_raddr_end got %0d exp 3", raddr); end
   endtask

   task automatic test_wrap();
      do_reset();
      rq2_wptr = 5'b11110;
      step();
      checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL wrap_start_rempty got %b exp 0", rempty); end
      rinc = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 20) rinc = 1'b0;
         checks++; if (raddr !== 4'(k % 16)) begin errors++; $display("FAIL wrap_raddr%0d got %0d exp %0d", k, raddr, k % 16); end
         checks++; if (rempty !== (k == 20)) begin errors++; $display("FAIL wrap_rempty%0d got %b exp %b", k, rempty, (k == 20)); end
         if (k >= 4) begin
            checks++; if (rlevel !== 5'(20 - k)) begin errors++; $display("FAIL wrap_rlevel%0d got %0d exp %0d", k, rlevel, 20 - k); end
         end
         if (k == 16) begin
            checks++; if (rptr !== 5'b11000) begin errors++; $display("FAIL wrap_rptr16 got %b exp 11000", rptr); end
         end
      end
      checks++; if (rptr !== 5'b11110) begin errors++; $display("FAIL wrap_rptr20 got %b exp 11110", rptr); end
      checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL wrap_runderflow got %b exp 0", runderflow); end
   endtask

   task automatic test_full_level();
      do_reset();
      rq2_wptr = 5'b11000;
      step();
      checks++; if (rlevel !== 5'd16) begin errors++; $display("FAIL full_rlevel got %0d exp 16", rlevel); end
      checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL full_rempty got %b exp 0", rempty); end
      checks++; if (raempty !== 1'b0) begin errors++; $display("FAIL full_raempty got %b exp 0", raempty); end
      rq2_wptr = 5'b00011;
      step();
      checks++; if (rlevel !== 5'd2) begin errors++; $display("FAIL ae_rlevel got %0d exp 2", rlevel); end
      checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL ae_raempty got %b exp 1", raempty); end
      checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL ae_rempty got %b exp 0", rempty); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      rq2_wptr = 5'b00011;
      step();
      rinc = 1'b1; rq2_wptr = 5'b00010;
      step();
      rinc = 1'b0;
      checks++; if (rlevel !== 5'd2) begin errors++; $display("FAIL b2b_rlevel got %0d exp 2", rlevel); end
      checks++; if (raddr !== 4'd1) begin errors++; $display("FAIL b2b_raddr got %0d exp 1", raddr); end
      checks++; if (rptr !== 5'b00001) begin errors++; $display("FAIL b2b_rptr got %b exp 00001", rptr); end
      checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL b2b_rempty got %b exp 0", rempty); end
   endtask

   task automatic test_underflow();
      do_reset();
      rinc = 1'b1;
      step();
      checks++; if (rptr !== 5'd0) begin errors++; $display("FAIL uf_rptr got %b exp 00000", rptr); end
      checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL uf_set got %b exp 1", runderflow); end
      checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL uf_rempty got %b exp 1", rempty); end
      rclr_err = 1'b1;
      step();
      checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL uf_set_wins got %b exp 1", runderflow); end
      rinc = 1'b0;
      step();
      rclr_err = 1'b0;
      checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL uf_clear got %b exp 0", runderflow); end
      step();
      checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL uf_stay_clear got %b exp 0", runderflow); end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      rq2_wptr = 5'b01100;
      step();
      rinc = 1'b1;
      step(); step(); step();
      checks++; if (rlevel !== 5'd5) begin errors++; $display("FAIL mid_rlevel got %0d exp 5", rlevel); end
      checks++; if (raddr !== 4'd3) begin errors++; $display("FAIL mid_raddr got %0d exp 3", raddr); end
      rrst = 1'b1;
      step();
      checks++; if (rptr !== 5'd0) begin errors++; $display("FAIL mid_rst_rptr got %b exp 00000", rptr); end
      checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL mid_rst_raddr got %0d exp 0", raddr); end
      checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL mid_rst_rempty got %b exp 1", rempty); end
      checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL mid_rst_raempty got %b exp 1", raempty); end
      checks++; if (rlevel !== 5'd0) begin errors++; $display("FAIL mid_rst_rlevel got %0d exp 0", rlevel); end
      checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL mid_rst_runderflow got %b exp 0", runderflow); end
      rrst = 1'b0; rinc = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_wrap();
      test_full_level();
      test_back_to_back();
      test_underflow();
      test_reset_mid_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
